// File: rtl/pipeline_scoreboard.sv
// pipeline_scoreboard: ID-stage hazard detector with an internal DEPTH-entry
// shift register of in-flight writers (entry 0 = EXE, entry 1 = MEM, ...).
// Produces a stall request, per-source forwarding selects and a saturating
// stall-cycle counter.
// Optional feature macro: SCOREBOARD_FORWARD_EN (define to enable operand
// forwarding; undefined gives stall-only hazard detection).
module pipeline_scoreboard #(
    parameter int unsigned REG_ADDR_W = 4,
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic                  id_two_src,
    input  logic                  id_wb_en,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic                  id_mem_read,
    input  logic                  flush,
    output logic                  stall_out,
    output logic [2:0]            fwd_sel1,
    output logic [2:0]            fwd_sel2,
    output logic [CNT_W-1:0]      stall_cnt
);

    typedef struct packed {
        logic                  valid;
        logic                  wb_en;
        logic                  mem_read;
        logic [REG_ADDR_W-1:0] dest;
    } entry_t;

    entry_t           ent [DEPTH];
    entry_t           new_ent;
    logic [DEPTH-1:0] hit1;
    logic [DEPTH-1:0] hit2;
    logic             raw_stall;
    logic             issue;

    // Per-entry source matches, gated by a live ID instruction.
    always_comb begin
        hit1 = '0;
        hit2 = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            hit1[k] = id_valid & ent[k].valid & ent[k].wb_en &
                      (ent[k].dest == id_src1);
            hit2[k] = id_valid & id_two_src & ent[k].valid & ent[k].wb_en &
                      (ent[k].dest == id_src2);
        end
    end

`ifdef SCOREBOARD_FORWARD_EN
    logic load_use1;
    logic load_use2;

    // Youngest match selects the forward source; a load in EXE cannot forward yet.
    always_comb begin
        fwd_sel1 = 3'd0;
        fwd_sel2 = 3'd0;
        for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
            if (hit1[k]) fwd_sel1 = 3'(k + 1);
            if (hit2[k]) fwd_sel2 = 3'(k + 1);
        end
        load_use1 = hit1[0] & ent[0].mem_read;
        load_use2 = hit2[0] & ent[0].mem_read;
        if (load_use1) fwd_sel1 = 3'd0;
        if (load_use2) fwd_sel2 = 3'd0;
        raw_stall = load_use1 | load_use2;
    end
`else
    logic [DEPTH-1:0] unused_mem_read;

    // Stall-only: any pending writer of a source blocks the ID instruction.
    always_comb begin
        fwd_sel1        = 3'd0;
        fwd_sel2        = 3'd0;
        raw_stall       = (|hit1) | (|hit2);
        unused_mem_read = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            unused_mem_read[k] = ent[k].mem_read;
        end
    end
`endif

    // A flushed ID instruction is dead, so it never needs to wait.
    always_comb begin
        stall_out        = raw_stall & ~flush;
        issue            = id_valid & ~stall_out & ~flush;
        new_ent          = '0;
        new_ent.valid    = issue;
        new_ent.wb_en    = issue & id_wb_en;
        new_ent.mem_read = issue & id_mem_read;
        new_ent.dest     = issue ? id_dest : '0;
    end

    // In-flight shift register; entry 0 takes the issued instruction or a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                ent[k] <= '0;
            end
        end else begin
            for (int k = 1; k < int'(DEPTH); k++) begin
                ent[k] <= ent[k-1];
            end
            ent[0] <= new_ent;
        end
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (stall_out && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule
